// File: rtl/comma_word_builder.sv
// Builds a word_size-bit word whose lowest 3'b101 has its MSB at index_in, one bit per clock, LSB first.
// Optional serial transmit of the finished word is enabled by defining COMMA_SER_TX_EN.
module comma_word_builder #(
  parameter int word_size  = 16,
  parameter int index_size = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [index_size-1:0] index_in,
  input  logic [word_size-1:0]  fill_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [word_size-1:0]  word_out
`ifdef COMMA_SER_TX_EN
  ,
  output logic                  ser_out,
  output logic                  ser_valid
`endif
);

  localparam int PW = $clog2(word_size);
  localparam int CW = PW + 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_BUILD = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [index_size-1:0] idx_q, idx_d;
  logic [word_size-1:0]  fill_q, fill_d;
  logic [word_size-1:0]  w_q, w_d;
  logic [CW-1:0]         p_q, p_d;
  logic                  prev1_q, prev1_d;
  logic                  prev2_q, prev2_d;
  logic [word_size-1:0]  word_out_q, word_out_d;
  logic                  err_q, err_d;

  logic bit_v;
  int   p_i;
  int   i_i;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    fill_d     = fill_q;
    w_d        = w_q;
    p_d        = p_q;
    prev1_d    = prev1_q;
    prev2_d    = prev2_q;
    word_out_d = word_out_q;
    err_d      = err_q;
    bit_v      = 1'b0;
    p_i        = int'(p_q);
    i_i        = int'(idx_q);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = index_in;
          fill_d  = fill_in;
          w_d     = '0;
          p_d     = '0;
          prev1_d = 1'b0;
          prev2_d = 1'b0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (i_i == 1 || i_i > word_size - 1) begin
          err_d      = 1'b1;
          word_out_d = '0;
          state_d    = ST_DONE;
        end else begin
          state_d = ST_BUILD;
        end
      end
      ST_BUILD: begin
        if (i_i != 0 && p_i == i_i) begin
          bit_v = 1'b1;
        end else if (i_i != 0 && p_i == i_i - 1) begin
          bit_v = 1'b0;
        end else if (i_i != 0 && p_i == i_i - 2) begin
          bit_v = 1'b1;
        end else if (i_i != 0 && (p_i == i_i - 3 || p_i == i_i - 4)) begin
          bit_v = 1'b0;
        end else if (i_i == 0 || p_i < i_i - 4) begin
          // prev bits start at 0, so the 1-0 prefix can only match once p >= 2
          bit_v = fill_q[p_q[PW-1:0]] & ~(prev2_q & ~prev1_q);
        end else begin
          bit_v = fill_q[p_q[PW-1:0]];
        end
        w_d[p_q[PW-1:0]] = bit_v;
        prev2_d = prev1_q;
        prev1_d = bit_v;
        p_d     = p_q + 1'b1;
        if (p_i == word_size - 1) begin
          err_d = 1'b0;
`ifdef COMMA_SER_TX_EN
          p_d     = '0;
          state_d = ST_SHIFT;
`else
          word_out_d = w_d;
          state_d    = ST_DONE;
`endif
        end
      end
`ifdef COMMA_SER_TX_EN
      ST_SHIFT: begin
        p_d = p_q + 1'b1;
        if (p_i == word_size - 1) begin
          word_out_d = w_q;
          state_d    = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      fill_q     <= '0;
      w_q        <= '0;
      p_q        <= '0;
      prev1_q    <= 1'b0;
      prev2_q    <= 1'b0;
      word_out_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      fill_q     <= fill_d;
      w_q        <= w_d;
      p_q        <= p_d;
      prev1_q    <= prev1_d;
      prev2_q    <= prev2_d;
      word_out_q <= word_out_d;
      err_q      <= err_d;
    end
  end

  assign busy     = (state_q == ST_CHECK) || (state_q == ST_BUILD) || (state_q == ST_SHIFT);
  assign done     = (state_q == ST_DONE);
  assign err      = err_q;
  assign word_out = word_out_q;

`ifdef COMMA_SER_TX_EN
  assign ser_valid = (state_q == ST_SHIFT);
  assign ser_out   = (state_q == ST_SHIFT) ? w_q[p_q[PW-1:0]] : 1'b0;
`endif

endmodule

// File: tb/tb_comma_word_builder.sv
// Randomized and directed bench for comma_word_builder against a spec-level word/timing model.
module tb_comma_word_builder;
  localparam int WS = 16;
  localparam int IS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [IS-1:0] index_in = '0;
  logic [WS-1:0] fill_in = '0;
  logic          busy, done, err;
  logic [WS-1:0] word_out;
`ifdef COMMA_SER_TX_EN
  logic          ser_out, ser_valid;
`endif

  comma_word_builder #(.word_size(WS), .index_size(IS)) dut (
    .clk(clk), .rst(rst), .start(start), .index_in(index_in), .fill_in(fill_in),
    .busy(busy), .done(done), .err(err), .word_out(word_out)
`ifdef COMMA_SER_TX_EN
    , .ser_out(ser_out), .ser_valid(ser_valid)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Word the spec describes: fill everywhere, 101 stamped at idx, two zero guards,
  // and any 101 that would complete below the code broken by clearing its top bit.
  function automatic logic [WS-1:0] build_word(input int idx, input logic [WS-1:0] fill);
    logic [WS-1:0] w;
    int low;
    w = fill;
    low = WS;
    if (idx != 0) begin
      w[idx] = 1'b1;
      w[idx-1] = 1'b0;
      w[idx-2] = 1'b1;
      if (idx >= 3) w[idx-3] = 1'b0;
      if (idx >= 4) w[idx-4] = 1'b0;
      low = (idx >= 4) ? idx - 4 : 0;
    end
    for (int p = 2; p < low; p++)
      if (w[p-2] && !w[p-1] && w[p]) w[p] = 1'b0;
    return w;
  endfunction

  function automatic int search(input logic [WS-1:0] w);
    for (int p = 2; p < WS; p++)
      if (w[p] && !w[p-1] && w[p-2]) return p;
    return 0;
  endfunction

`ifdef COMMA_SER_TX_EN
  localparam int LEGAL_LAT = 2*WS + 2;
`else
  localparam int LEGAL_LAT = WS + 2;
`endif

  // Timing model: a request in flight completes lat cycles after its start cycle.
  logic          m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [WS-1:0] m_word = '0, m_res = '0;
  logic          m_res_err = 1'b0;
  bit            pending = 1'b0;
  int            cnt = 0, lat = 0;

  always @(posedge clk) begin
    if (rst) begin
      pending = 0; m_busy = 0; m_done = 0; m_err = 0; m_word = '0;
    end else if (pending) begin
      cnt++;
      if (cnt == lat) begin
        pending = 0; m_busy = 0; m_done = 1; m_word = m_res; m_err = m_res_err;
      end
    end else begin
      bit was_done;
      was_done = m_done;
      m_done = 0;
      if (start && !was_done) begin
        pending = 1; cnt = 1; m_busy = 1;
        m_res_err = (int'(index_in) == 1 || int'(index_in) > WS - 1);
        m_res = m_res_err ? '0 : build_word(int'(index_in), fill_in);
        lat = m_res_err ? 2 : LEGAL_LAT;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("word_out", 32'(word_out), 32'(m_word));
    if (m_done) check("err", 32'(err), 32'(m_err));
  end

  task automatic run_req(input int idx, input logic [WS-1:0] fill, output int l);
    @(negedge clk);
    start = 1'b1; index_in = IS'(idx); fill_in = fill;
    @(negedge clk);
    start = 1'b0;
    l = 1;
    while (!done && l < 200) begin
      @(negedge clk);
      l++;
    end
    if (!done) begin
      $display("FAIL timeout idx=%0d actual=no_done required=done", idx);
      n_checks++;
    end
  endtask

  int l, dcount, idx;
  logic [WS-1:0] f;

  initial begin
    check("pin_5_ffff", 32'(build_word(5, 16'hFFFF)), 32'h0000FFE9);
    check("pin_0_5555", 32'(build_word(0, 16'h5555)), 32'h00001111);
    check("pin_0_ffff", 32'(build_word(0, 16'hFFFF)), 32'h0000FFFF);
    check("pin_2_0000", 32'(build_word(2, 16'h0000)), 32'h00000005);
    check("pin_15_0000", 32'(build_word(15, 16'h0000)), 32'h0000A000);
    check("pin_search", 32'(search(16'h1111)), 32'd0);

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_word", 32'(word_out), 32'd0);
    rst = 1'b0;

    run_req(5, 16'hFFFF, l);
    check("lat_5", 32'(l), 32'(LEGAL_LAT));
    check("word_5", 32'(word_out), 32'h0000FFE9);
    check("err_5", 32'(err), 32'd0);
    run_req(0, 16'h5555, l);
    check("word_0a", 32'(word_out), 32'h00001111);
    check("search_0a", 32'(search(word_out)), 32'd0);
    run_req(0, 16'hFFFF, l);
    check("word_0b", 32'(word_out), 32'h0000FFFF);
    run_req(2, 16'h0000, l);
    check("word_2", 32'(word_out), 32'h00000005);
    run_req(15, 16'h0000, l);
    check("word_15", 32'(word_out), 32'h0000A000);

    // illegal index, with starts pulsed in the busy and done cycles
    @(negedge clk);
    start = 1'b1; index_in = 4'd1; fill_in = 16'hFFFF;
    @(negedge clk);
    index_in = 4'd5;
    @(negedge clk);
    check("ill_done", 32'(done), 32'd1);
    check("ill_err", 32'(err), 32'd1);
    check("ill_word", 32'(word_out), 32'd0);
    @(negedge clk);
    start = 1'b0;
    dcount = 0;
    repeat (WS + 6) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("ignored_starts", 32'(dcount), 32'd0);

    // reset mid-build
    @(negedge clk);
    start = 1'b1; index_in = 4'd7; fill_in = 16'hA5A5;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_word", 32'(word_out), 32'd0);
    rst = 1'b0;
    dcount = 0;
    repeat (WS + 6) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("midrst_nodone", 32'(dcount), 32'd0);

    for (int t = 0; t < 40; t++) begin
      idx = int'($urandom_range(0, WS - 2));
      if (idx == 1) idx = 0;
      if (t % 3 == 2) idx = WS - 1;
      f = WS'($urandom);
      run_req(idx, f, l);
      check("rand_lat", 32'(l), 32'(LEGAL_LAT));
      check("rand_err", 32'(err), 32'd0);
      check("rand_search", 32'(search(word_out)), 32'(idx));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
